// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths and constants.
// Used by the fetch path and decode-side buffers.
package cpu_pkg;

   localparam int PC_W   = 14;
   localparam int INST_W = 32;

   localparam logic [INST_W-1:0] NOP_INST = 32'h0;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue.
// One write port, one asynchronous read port, no reset.
module fetch_queue_mem #(
   parameter int DEPTH = 4,
   parameter int W     = 46,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between the program counter and decode.
// Registered ready (no out_ready -> in_ready path); flush drops all entries.
module fetch_queue #(
   parameter int DEPTH  = 4,
   parameter int PC_W   = cpu_pkg::PC_W,
   parameter int INST_W = cpu_pkg::INST_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic [PC_W-1:0]          in_pc,
   input  logic [INST_W-1:0]        in_inst,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [PC_W-1:0]          out_pc,
   output logic [INST_W-1:0]        out_inst,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count
);

   import cpu_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = PC_W + INST_W;

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          push;
   logic          pop;
   logic [EW-1:0] wdata;
   logic [EW-1:0] rdata;

   assign in_ready  = (cnt != CW'(DEPTH));
   assign out_valid = (cnt != '0);

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   assign wdata = {in_pc, in_inst};

   // A flushed cycle's incoming word never lands in storage.
   fetch_queue_mem #(
      .DEPTH (DEPTH),
      .W     (EW),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (push & ~flush),
      .waddr (wr_ptr),
      .wdata (wdata),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   end

   always_comb begin
      out_pc   = '0;
      out_inst = NOP_INST;
      if (out_valid) begin
         out_pc   = rdata[EW-1:INST_W];
         out_inst = rdata[INST_W-1:0];
      end
   end

   assign count = cnt;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed scenarios then random traffic.
// Driver keeps an occupancy model; negedge monitor checks heads and flags.
module tb_fetch_queue;

   localparam int DEPTH = 4;

   typedef struct {
      logic [13:0] pc;
      logic [31:0] inst;
   } ent_t;

   logic        clk = 0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [13:0] in_pc;
   logic [31:0] in_inst;
   logic        in_ready;
   logic        out_valid;
   logic [13:0] out_pc;
   logic [31:0] out_inst;
   logic        out_ready;
   logic [2:0]  count;

   ent_t sb[$];
   int   mcount = 0;
   int   total  = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   fetch_queue dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_pc     (in_pc),
      .in_inst   (in_inst),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_pc    (out_pc),
      .out_inst  (out_inst),
      .out_ready (out_ready),
      .count     (count)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end else begin
         passed++;
      end
   endtask

   // Monitor: flags follow the model occupancy; popped heads match in order.
   always @(negedge clk) begin
      chk("count", 64'(count), 64'(mcount));
      chk("in_ready", 64'(in_ready), 64'(mcount != DEPTH));
      chk("out_valid", 64'(out_valid), 64'(mcount != 0));
      if (!out_valid) begin
         chk("idle_pc", 64'(out_pc), 64'h0);
         chk("idle_inst", 64'(out_inst), 64'h0);
      end else if (out_ready) begin
         if (sb.size() == 0) begin
            chk("sb_nonempty", 64'(sb.size()), 64'd1);
         end else begin
            ent_t e;
            e = sb.pop_front();
            chk("head_pc", 64'(out_pc), 64'(e.pc));
            chk("head_inst", 64'(out_inst), 64'(e.inst));
         end
      end
   end

   // Drive one cycle starting at posedge+1; model updates after the edge.
   task automatic cyc(input bit v, input logic [13:0] pc,
                      input logic [31:0] inst, input bit r, input bit f);
      bit acc;
      bit pp;
      ent_t e;
      in_valid  = v;
      in_pc     = pc;
      in_inst   = inst;
      out_ready = r;
      flush     = f;
      acc = v && (mcount < DEPTH) && !f && rst_n;
      pp  = r && (mcount > 0) && !f && rst_n;
      @(posedge clk);
      if (rst_n) begin
         if (f) begin
            sb.delete();
            mcount = 0;
         end else begin
            if (acc) begin
               e.pc   = pc;
               e.inst = inst;
               sb.push_back(e);
            end
            mcount = mcount + int'(acc) - int'(pp);
         end
      end
      #1;
   endtask

   initial begin
      rst_n     = 0;
      flush     = 0;
      in_valid  = 1;
      in_pc     = 14'h3;
      in_inst   = 32'hdead;
      out_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_pc", 64'(out_pc), 64'd0);
      chk("rst_out_inst", 64'(out_inst), 64'd0);
      rst_n = 1;

      // Fill, then a refused fifth push
      for (int i = 8; i < 12; i++) cyc(1, 14'(i), 32'h1000 + 32'(i), 0, 0);
      chk("fill_count", 64'(count), 64'd4);
      chk("fill_in_ready", 64'(in_ready), 64'd0);
      cyc(1, 14'd12, 32'h100c, 0, 0);
      chk("full_hold", 64'(count), 64'd4);

      // Drain in order
      for (int i = 0; i < 5; i++) cyc(0, 14'd0, 32'd0, 1, 0);
      chk("drain_count", 64'(count), 64'd0);
      chk("drain_valid", 64'(out_valid), 64'd0);

      // Streaming at occupancy 2 wraps the pointers
      cyc(1, 14'd20, 32'h2000, 0, 0);
      cyc(1, 14'd21, 32'h2001, 0, 0);
      for (int i = 0; i < 10; i++)
         cyc(1, 14'(22 + i), 32'h2002 + 32'(i), 1, 0);
      chk("stream_count", 64'(count), 64'd2);

      // Flush at occupancy 3 with push and pop requested
      cyc(1, 14'd40, 32'h4000, 0, 0);
      chk("pre_flush", 64'(count), 64'd3);
      cyc(1, 14'h3ff, 32'hbad0bad0, 1, 1);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_ready", 64'(in_ready), 64'd1);
      cyc(1, 14'd50, 32'h5000, 0, 0);
      cyc(0, 14'd0, 32'd0, 1, 0);
      cyc(0, 14'd0, 32'd0, 1, 0);

      // Async reset between edges at occupancy 2
      cyc(1, 14'd60, 32'h6000, 0, 0);
      cyc(1, 14'd61, 32'h6001, 0, 0);
      chk("pre_areset", 64'(count), 64'd2);
      in_valid = 0;
      #2;
      rst_n = 0;
      sb.delete();
      mcount = 0;
      #1;
      chk("areset_count", 64'(count), 64'd0);
      chk("areset_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1;
      cyc(1, 14'd70, 32'h7000, 0, 0);
      chk("post_rst_push", 64'(count), 64'd1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom % 4) != 0, 14'($urandom), $urandom,
             ($urandom % 3) != 0, ($urandom % 25) == 0);
      end

      in_valid = 0;
      flush    = 0;
      for (int i = 0; i < 6; i++) cyc(0, 14'd0, 32'd0, 1, 0);
      chk("final_empty", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
